pc_gen: RTL and testbench

- Parametrised next-PC generator and fetch-request source; successor to the combinational PC select in the fetch stage.
- Holds the architectural fetch PC in a register and arbitrates NUM_REDIRECT prioritised redirect sources (interrupt, trap return, CSR write, branch/jump, ...) against sequential PC + INST_BYTES.
- Presents the PC to the instruction bus over a valid/ready handshake.
- Redirects that arrive while a request is stalled are parked in a pending register; the in-flight request is never dropped.

---
 rtl/pc_gen.sv | 116 +++++++++++
 tb/tb_pc_gen.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Next-PC generator: holds the fetch PC, arbitrates prioritised redirects against
// sequential fetch, and parks redirects that arrive while the request is stalled.
module pc_gen #(
  parameter int               XLEN         = 64,
  parameter int               NUM_REDIRECT = 4,
  parameter logic [XLEN-1:0]  RESET_PC     = 64'h0000_0000_8000_0000,
  parameter int               INST_BYTES   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REDIRECT-1:0]      redirect_valid,
  input  logic [NUM_REDIRECT*XLEN-1:0] redirect_pc,
  input  logic                         stall,
  input  logic                         fetch_ready,
  output logic                         fetch_valid,
  output logic [XLEN-1:0]              fetch_pc,
  output logic                         redirect_pending,
  output logic                         squash,
  output logic                         misalign
);

  // state | meaning
  // BOOT  | first cycle out of reset, no request presented yet
  // RUN   | request always valid; only reset leaves this state
  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_e;

  localparam logic [XLEN-1:0] OFF_MASK = XLEN'(INST_BYTES - 1);
  localparam logic [XLEN-1:0] PC_INC   = XLEN'(INST_BYTES);

  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              pend_q, pend_d;
  logic [XLEN-1:0]   pend_pc_q, pend_pc_d;
  logic              squash_q, squash_d;
  logic              misalign_q, misalign_d;

  logic              fire;
  logic              any_redir;
  logic [XLEN-1:0]   raw_tgt;
  logic [XLEN-1:0]   tgt;

  assign fire      = valid_q & fetch_ready & ~stall;
  assign any_redir = |redirect_valid;

  // Scan from lowest priority upward so the lowest active index wins.
  always_comb begin
    raw_tgt = '0;
    for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
      if (redirect_valid[i]) raw_tgt = redirect_pc[i*XLEN +: XLEN];
    end
  end

  assign tgt = raw_tgt & ~OFF_MASK;

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_pc_d  = pend_pc_q;
    // A parked redirect squashes again once the held (wrong-path) request issues.
    squash_d   = any_redir | (fire & pend_q);
    misalign_d = any_redir & (|(raw_tgt & OFF_MASK));

    case (state_q)
      BOOT: begin
        state_d = RUN;
        valid_d = 1'b1;
      end
      RUN: valid_d = 1'b1;
    endcase

    if (fire) begin
      if (any_redir) begin
        pc_d   = tgt;
        pend_d = 1'b0;
      end else if (pend_q) begin
        pc_d   = pend_pc_q;
        pend_d = 1'b0;
      end else begin
        pc_d = pc_q + PC_INC;
      end
    end else if (any_redir) begin
      pend_pc_d = tgt;
      pend_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= BOOT;
      valid_q    <= 1'b0;
      pc_q       <= RESET_PC;
      pend_q     <= 1'b0;
      pend_pc_q  <= '0;
      squash_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      squash_q   <= squash_d;
      misalign_q <= misalign_d;
    end
  end

  assign fetch_valid      = valid_q;
  assign fetch_pc         = pc_q;
  assign redirect_pending = pend_q;
  assign squash           = squash_q;
  assign misalign         = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed vector bench for pc_gen: table of per-cycle inputs and expected
// registered outputs, plus hand-written reset/boot sequences.
module tb_pc_gen;

  logic         clk;
  logic         reset;
  logic [3:0]   redirect_valid;
  logic [255:0] redirect_pc;
  logic         stall;
  logic         fetch_ready;
  logic         fetch_valid;
  logic [63:0]  fetch_pc;
  logic         redirect_pending;
  logic         squash;
  logic         misalign;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  pc_gen #(
    .XLEN(64), .NUM_REDIRECT(4), .RESET_PC(64'h0000_0000_8000_0000), .INST_BYTES(4)
  ) dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall), .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .redirect_pending(redirect_pending), .squash(squash), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [3:0]   rv;
    logic [255:0] rpc;
    logic         st;
    logic         rd;
    logic         e_valid;
    logic [63:0]  e_pc;
    logic         e_pend;
    logic         e_sq;
    logic         e_mis;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [255:0] at(int idx, logic [63:0] v);
    logic [255:0] r;
    r = '0;
    r[idx*64 +: 64] = v;
    return r;
  endfunction

  function automatic void add(string n, logic [3:0] rv, logic [255:0] rpc, logic st, logic rd,
                              logic ev, logic [63:0] epc, logic ep, logic es, logic em);
    vec_t v;
    v.name = n; v.rv = rv; v.rpc = rpc; v.st = st; v.rd = rd;
    v.e_valid = ev; v.e_pc = epc; v.e_pend = ep; v.e_sq = es; v.e_mis = em;
    vecs.push_back(v);
  endfunction

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic chk_all(string n, logic ev, logic [63:0] epc, logic ep, logic es, logic em);
    chk({n, ".valid"}, 64'(fetch_valid), 64'(ev));
    chk({n, ".pc"}, fetch_pc, epc);
    chk({n, ".pend"}, 64'(redirect_pending), 64'(ep));
    chk({n, ".squash"}, 64'(squash), 64'(es));
    chk({n, ".misalign"}, 64'(misalign), 64'(em));
  endtask

  // Called at a negedge: drive one cycle of inputs, check after the posedge, return at negedge.
  task automatic step(vec_t v);
    redirect_valid = v.rv;
    redirect_pc    = v.rpc;
    stall          = v.st;
    fetch_ready    = v.rd;
    @(posedge clk);
    #1;
    chk_all(v.name, v.e_valid, v.e_pc, v.e_pend, v.e_sq, v.e_mis);
    @(negedge clk);
  endtask

  task automatic step_args(string n, logic [3:0] rv, logic [255:0] rpc, logic st, logic rd,
                           logic ev, logic [63:0] epc, logic ep, logic es, logic em);
    vec_t v;
    v.name = n; v.rv = rv; v.rpc = rpc; v.st = st; v.rd = rd;
    v.e_valid = ev; v.e_pc = epc; v.e_pend = ep; v.e_sq = es; v.e_mis = em;
    step(v);
  endtask

  initial begin
    //   name        rv       rpc                                                   st rd  valid pc                       pend sq mis
    add("boot",      4'b0000, '0,                                                   0, 1,  1, 64'h8000_0000,             0, 0, 0);
    add("seq1",      4'b0000, '0,                                                   0, 1,  1, 64'h8000_0004,             0, 0, 0);
    add("seq2",      4'b0000, '0,                                                   0, 1,  1, 64'h8000_0008,             0, 0, 0);
    add("prio",      4'b1010, at(1, 64'h9000_0000) | at(3, 64'hA000_0000),         0, 1,  1, 64'h9000_0000,             0, 1, 0);
    add("redir0",    4'b0001, at(0, 64'h8000_0008),                                 0, 1,  1, 64'h8000_0008,             0, 1, 0);
    add("seq3",      4'b0000, '0,                                                   0, 1,  1, 64'h8000_000C,             0, 0, 0);
    add("seq4",      4'b0000, '0,                                                   0, 1,  1, 64'h8000_0010,             0, 0, 0);
    add("park2",     4'b0100, at(2, 64'h8000_2000),                                 0, 0,  1, 64'h8000_0010,             1, 1, 0);
    add("parkwait",  4'b0000, '0,                                                   0, 0,  1, 64'h8000_0010,             1, 0, 0);
    add("park3",     4'b1000, at(3, 64'h8000_3000),                                 0, 0,  1, 64'h8000_0010,             1, 1, 0);
    add("unpark",    4'b0000, '0,                                                   0, 1,  1, 64'h8000_3000,             0, 1, 0);
    add("seq5",      4'b0000, '0,                                                   0, 1,  1, 64'h8000_3004,             0, 0, 0);
    add("stall1",    4'b0000, '0,                                                   1, 1,  1, 64'h8000_3004,             0, 0, 0);
    add("stall2",    4'b0000, '0,                                                   1, 1,  1, 64'h8000_3004,             0, 0, 0);
    add("stall3",    4'b0000, '0,                                                   1, 1,  1, 64'h8000_3004,             0, 0, 0);
    add("stall4",    4'b0000, '0,                                                   1, 1,  1, 64'h8000_3004,             0, 0, 0);
    add("unstall",   4'b0000, '0,                                                   0, 1,  1, 64'h8000_3008,             0, 0, 0);
    add("misal",     4'b0001, at(0, 64'h8000_0006),                                 0, 1,  1, 64'h8000_0004,             0, 1, 1);
    add("misal_end", 4'b0000, '0,                                                   0, 1,  1, 64'h8000_0008,             0, 0, 0);
    add("misal_pk",  4'b0001, at(0, 64'h8000_0101),                                 0, 0,  1, 64'h8000_0008,             1, 1, 1);
    add("misal_up",  4'b0000, '0,                                                   0, 1,  1, 64'h8000_0100,             0, 1, 0);
    add("seq6",      4'b0000, '0,                                                   0, 1,  1, 64'h8000_0104,             0, 0, 0);
    add("top",       4'b0010, at(1, 64'hFFFF_FFFF_FFFF_FFFC),                       0, 1,  1, 64'hFFFF_FFFF_FFFF_FFFC,   0, 1, 0);
    add("wrap",      4'b0000, '0,                                                   0, 1,  1, 64'h0,                     0, 0, 0);
    add("wrap1",     4'b0000, '0,                                                   0, 1,  1, 64'h4,                     0, 0, 0);
    add("pk_new",    4'b0100, at(2, 64'h1000),                                      0, 0,  1, 64'h4,                     1, 1, 0);
    add("new_wins",  4'b0001, at(0, 64'h2000),                                      0, 1,  1, 64'h2000,                  0, 1, 0);
    add("seq7",      4'b0000, '0,                                                   0, 1,  1, 64'h2004,                  0, 0, 0);

    reset = 1'b0;
    redirect_valid = '0;
    redirect_pc = '0;
    stall = 1'b0;
    fetch_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_all("reset", 1'b0, RST_PC, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("cycle0.valid", 64'(fetch_valid), 64'h0);
    chk("cycle0.pc", fetch_pc, RST_PC);

    foreach (vecs[k]) step(vecs[k]);

    // Park a redirect, then pull reset between clock edges.
    step_args("pk_rst", 4'b0001, at(0, 64'h5000), 0, 0, 1, 64'h2004, 1, 1, 0);
    redirect_valid = '0;
    redirect_pc = '0;
    @(posedge clk);
    #1;
    chk("pre_rst.pend", 64'(redirect_pending), 64'h1);
    #1;
    reset = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, RST_PC, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    step_args("reboot", 4'b0000, '0, 0, 1, 1, RST_PC, 0, 0, 0);
    step_args("lost_pend", 4'b0000, '0, 0, 1, 1, 64'h8000_0004, 0, 0, 0);

    // Redirect during BOOT parks because no request is valid yet.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step_args("boot_pk", 4'b0001, at(0, 64'h7000), 0, 1, 1, RST_PC, 1, 1, 0);
    step_args("boot_up", 4'b0000, '0, 0, 1, 1, 64'h7000, 0, 1, 0);
    step_args("boot_seq", 4'b0000, '0, 0, 1, 1, 64'h7004, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
